// File: rtl/ulpi_line_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ulpi_line_ctrl_if                                            |
// | Description : Bus bundle for ulpi_line_ctrl: raw PHY pins, registered      |
// |               pins, UTMI+ line status and the register-write handshake.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ulpi_line_ctrl_if;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_data;
  logic       iob_dir_o;
  logic       iob_nxt_o;
  logic [7:0] iob_dat_o;
  logic [1:0] line_state_o;
  logic [1:0] vbus_state_o;
  logic [1:0] rx_event_o;
  logic       high_speed_o;
  logic       usb_reset_o;
  logic       suspend_o;
  logic [3:0] state_o;
  logic       reg_req_o;
  logic       reg_busy_i;
  logic       reg_done_i;
  logic       reg_stop_o;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_data_o;

  // master: the line controller; slave: PHY pins plus the register-write engine
  modport master (
    input  ulpi_dir, ulpi_nxt, ulpi_data, reg_busy_i, reg_done_i,
    output iob_dir_o, iob_nxt_o, iob_dat_o, line_state_o, vbus_state_o,
           rx_event_o, high_speed_o, usb_reset_o, suspend_o, state_o,
           reg_req_o, reg_stop_o, reg_addr_o, reg_data_o
  );

  modport slave (
    output ulpi_dir, ulpi_nxt, ulpi_data, reg_busy_i, reg_done_i,
    input  iob_dir_o, iob_nxt_o, iob_dat_o, line_state_o, vbus_state_o,
           rx_event_o, high_speed_o, usb_reset_o, suspend_o, state_o,
           reg_req_o, reg_stop_o, reg_addr_o, reg_data_o
  );
endinterface
`default_nettype wire

// File: rtl/ulpi_line_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ulpi_line_ctrl                                               |
// | Description : ULPI line-state controller: RX CMD decode, bus reset detect, |
// |               HS chirp negotiation with FS fallback. Optional suspend      |
// |               detection is enabled by defining ULPI_LINE_SUSPEND_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ulpi_line_ctrl #(
  parameter int HIGH_SPEED    = 1,
  parameter int CNTW          = 20,
  parameter int RESET_CYC     = 190000,
  parameter int SUSPEND_CYC   = 190000,
  parameter int CHIRPK_CYC    = 66000,
  parameter int KJ_PAIRS      = 3,
  parameter int KJ_CYC        = 120,
  parameter int CHIRP_TMO_CYC = 150000,
  parameter int SWITCH_CYC    = 6000
) (
  input wire logic         clock,
  input wire logic         reset,
  ulpi_line_ctrl_if.master bus
);

  localparam logic [3:0] c_st_init    = 4'd0;
  localparam logic [3:0] c_st_write   = 4'd1;
  localparam logic [3:0] c_st_wait    = 4'd2;
  localparam logic [3:0] c_st_idle    = 4'd3;
  localparam logic [3:0] c_st_reset   = 4'd4;
  localparam logic [3:0] c_st_chirp   = 4'd5;
  localparam logic [3:0] c_st_chirpk  = 4'd6;
  localparam logic [3:0] c_st_stop    = 4'd7;
  localparam logic [3:0] c_st_kj      = 4'd8;
  localparam logic [3:0] c_st_fsstart = 4'd9;
  localparam logic [3:0] c_st_fswait  = 4'd10;
`ifdef ULPI_LINE_SUSPEND_EN
  localparam logic [3:0] c_st_suspend = 4'd11;
  localparam logic [CNTW-1:0] c_suspend_cyc = CNTW'(SUSPEND_CYC);
`endif

  localparam logic [CNTW-1:0] c_reset_cyc  = CNTW'(RESET_CYC);
  localparam logic [CNTW-1:0] c_chirpk_cyc = CNTW'(CHIRPK_CYC);
  localparam logic [CNTW-1:0] c_kj_cyc     = CNTW'(KJ_CYC);
  localparam logic [CNTW-1:0] c_tmo_cyc    = CNTW'(CHIRP_TMO_CYC);
  localparam logic [CNTW-1:0] c_switch_cyc = CNTW'(SWITCH_CYC);
  localparam logic [2:0]      c_kj_pairs   = 3'(KJ_PAIRS);
  localparam logic            c_hs_en      = (HIGH_SPEED != 0);

  localparam logic [1:0] c_ls_se0 = 2'b00;
  localparam logic [1:0] c_ls_j   = 2'b01;

  logic            r_iob_dir;
  logic            r_iob_nxt;
  logic [7:0]      r_iob_dat;
  logic [1:0]      r_line;
  logic [1:0]      r_vbus;
  logic [1:0]      r_rx_event;
  logic [CNTW-1:0] r_timer;
  logic [CNTW-1:0] r_kj_tmo;
  logic [2:0]      r_kj_pairs;
  logic [3:0]      r_state;
  logic [3:0]      r_ret_state;
  logic [7:0]      r_reg_addr;
  logic [7:0]      r_reg_data;
  logic            r_high_speed;
  logic            r_usb_reset;

  logic            w_rx_cmd;
  logic            w_line_chg;
  logic            w_hold;
  logic            w_state_enter;
  logic            w_timer_clr;
  logic [3:0]      w_state_next;
  logic            w_load;
  logic [7:0]      w_wr_addr;
  logic [7:0]      w_wr_data;
  logic [3:0]      w_wr_ret;
  logic            w_hs_set;
  logic            w_hs_clr;
  logic            w_reg_req;
  logic            w_reg_stop;

  // Pin capture has no reset so the registered pins always mirror the PHY.
  always_ff @(posedge clock) begin
    r_iob_dir <= bus.ulpi_dir;
    r_iob_nxt <= bus.ulpi_nxt;
    r_iob_dat <= bus.ulpi_data;
  end

  assign w_rx_cmd      = r_iob_dir && bus.ulpi_dir && !bus.ulpi_nxt;
  assign w_line_chg    = w_rx_cmd && (bus.ulpi_data[1:0] != r_line);
  assign w_hold        = r_iob_dir || bus.ulpi_dir;
  assign w_state_enter = (w_state_next != r_state);
  assign w_timer_clr   = w_line_chg ||
                         (w_state_enter && ((w_state_next == c_st_chirpk) ||
                                            (w_state_next == c_st_kj) ||
                                            (w_state_next == c_st_fswait)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_line     <= 2'b00;
      r_vbus     <= 2'b00;
      r_rx_event <= 2'b00;
    end else if (w_rx_cmd) begin
      r_line     <= bus.ulpi_data[1:0];
      r_vbus     <= bus.ulpi_data[3:2];
      r_rx_event <= bus.ulpi_data[5:4];
    end
  end

  // Line timer measures time since the last line change or state entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_timer_clr) begin
      r_timer <= '0;
    end else if (r_timer != '1) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Chirp timeout and pair counter keep running through bus turnarounds,
  // since the host's K/J chirps arrive as RX CMDs while dir is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_kj_tmo   <= '0;
      r_kj_pairs <= 3'd0;
    end else if (w_state_enter && (w_state_next == c_st_kj)) begin
      r_kj_tmo   <= '0;
      r_kj_pairs <= 3'd0;
    end else if (r_state == c_st_kj) begin
      if (r_kj_tmo != '1) begin
        r_kj_tmo <= r_kj_tmo + 1'b1;
      end
      if (w_line_chg && (bus.ulpi_data[1:0] == c_ls_j) && (r_kj_pairs != 3'd7)) begin
        r_kj_pairs <= r_kj_pairs + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_st_init;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_wr_addr    = 8'h00;
    w_wr_data    = 8'h00;
    w_wr_ret     = r_state;
    w_hs_set     = 1'b0;
    w_hs_clr     = 1'b0;
    if (!w_hold) begin
      case (r_state)
        c_st_init: begin
          w_state_next = c_st_write;
          w_load       = 1'b1;
          w_wr_addr    = 8'h8A;
          w_wr_data    = 8'h00;
          w_wr_ret     = c_st_fsstart;
        end
        c_st_write: begin
          if (bus.reg_busy_i) begin
            w_state_next = c_st_wait;
          end
        end
        c_st_wait: begin
          if (bus.reg_done_i) begin
            w_state_next = r_ret_state;
          end
        end
        c_st_idle: begin
          // Reset is tested first so it wins over a simultaneous suspend.
          if ((r_line == c_ls_se0) && (r_timer > c_reset_cyc)) begin
            w_state_next = c_st_reset;
`ifdef ULPI_LINE_SUSPEND_EN
          end else if (!r_high_speed && (r_line == c_ls_j) &&
                       (r_timer > c_suspend_cyc)) begin
            w_state_next = c_st_suspend;
`endif
          end
        end
        c_st_reset: begin
          if (r_high_speed) begin
            w_state_next = c_st_fsstart;
          end else if (c_hs_en) begin
            w_state_next = c_st_chirp;
          end else if (r_line != c_ls_se0) begin
            w_state_next = c_st_idle;
          end
        end
        c_st_chirp: begin
          w_state_next = c_st_write;
          w_load       = 1'b1;
          w_wr_addr    = 8'h84;
          w_wr_data    = 8'h54;
          w_wr_ret     = c_st_chirpk;
        end
        c_st_chirpk: begin
          if ((r_timer >= c_chirpk_cyc) && !bus.reg_busy_i) begin
            w_state_next = c_st_stop;
          end
        end
        c_st_stop: begin
          if (bus.reg_busy_i) begin
            w_state_next = c_st_kj;
          end
        end
        c_st_kj: begin
          if ((r_kj_pairs >= c_kj_pairs) && (r_timer > c_kj_cyc)) begin
            w_state_next = c_st_write;
            w_load       = 1'b1;
            w_wr_addr    = 8'h84;
            w_wr_data    = 8'h40;
            w_wr_ret     = c_st_idle;
            w_hs_set     = 1'b1;
          end else if (r_kj_tmo >= c_tmo_cyc) begin
            w_state_next = c_st_fsstart;
            w_hs_clr     = 1'b1;
          end
        end
        c_st_fsstart: begin
          w_state_next = c_st_write;
          w_load       = 1'b1;
          w_wr_addr    = 8'h84;
          w_wr_data    = 8'h45;
          w_wr_ret     = c_st_fswait;
          w_hs_clr     = 1'b1;
        end
        c_st_fswait: begin
          if (r_timer >= c_switch_cyc) begin
            w_state_next = ((r_line == c_ls_se0) && c_hs_en) ? c_st_chirp : c_st_idle;
          end
        end
`ifdef ULPI_LINE_SUSPEND_EN
        c_st_suspend: begin
          if (r_line != c_ls_j) begin
            w_state_next = c_st_idle;
          end
        end
`endif
        default: begin
          w_state_next = c_st_init;
        end
      endcase
    end
  end

  always_comb begin
    w_reg_req  = (r_state == c_st_write);
    w_reg_stop = (r_state == c_st_chirpk) && !w_hold && !bus.reg_busy_i &&
                 (r_timer >= c_chirpk_cyc);
  end

  // Address/data load only on the way into WRITE, so they hold while requesting.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_reg_addr   <= 8'h00;
      r_reg_data   <= 8'h00;
      r_ret_state  <= c_st_init;
      r_high_speed <= 1'b0;
      r_usb_reset  <= 1'b0;
    end else begin
      if (w_load) begin
        r_reg_addr  <= w_wr_addr;
        r_reg_data  <= w_wr_data;
        r_ret_state <= w_wr_ret;
      end
      if (w_hs_set) begin
        r_high_speed <= 1'b1;
      end else if (w_hs_clr) begin
        r_high_speed <= 1'b0;
      end
      if (w_state_next == c_st_reset) begin
        r_usb_reset <= 1'b1;
      end else if (w_state_next == c_st_idle) begin
        r_usb_reset <= 1'b0;
      end
    end
  end

`ifdef ULPI_LINE_SUSPEND_EN
  logic r_suspend;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_suspend <= 1'b0;
    end else begin
      r_suspend <= (w_state_next == c_st_suspend);
    end
  end

  assign bus.suspend_o = r_suspend;
`else
  assign bus.suspend_o = 1'b0;
`endif

  assign bus.iob_dir_o    = r_iob_dir;
  assign bus.iob_nxt_o    = r_iob_nxt;
  assign bus.iob_dat_o    = r_iob_dat;
  assign bus.line_state_o = r_line;
  assign bus.vbus_state_o = r_vbus;
  assign bus.rx_event_o   = r_rx_event;
  assign bus.high_speed_o = r_high_speed;
  assign bus.usb_reset_o  = r_usb_reset;
  assign bus.state_o      = r_state;
  assign bus.reg_req_o    = w_reg_req;
  assign bus.reg_stop_o   = w_reg_stop;
  assign bus.reg_addr_o   = r_reg_addr;
  assign bus.reg_data_o   = r_reg_data;

endmodule
`default_nettype wire
